// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token symbols and alignment FSM states.
// Used by both the encoder and the decoder side of the link.
package tmds_pkg;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_LOCKED    = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } align_state_t;

    function automatic logic is_ctrl(input logic [9:0] s);
        return (s == CTRL_00) || (s == CTRL_01) ||
               (s == CTRL_10) || (s == CTRL_11);
    endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Symbol-alignment FSM: counts control tokens to declare lock and
// requests a bitslip when no token has been seen for too long.
module tmds_align_fsm
    import tmds_pkg::*;
#(
    parameter int LOCK_CNT       = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int SLIP_WAIT      = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_vld,
    input  logic i_ctrl,
    output logic o_locked,
    output logic o_bitslip
);

    localparam int TW = $clog2(LOCK_CNT) + 1;
    localparam int IW = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int WW = $clog2(SLIP_WAIT) + 1;

    localparam logic [TW-1:0] TOK_LAST  = TW'(LOCK_CNT - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(SEARCH_TIMEOUT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);

    align_state_t  r_state, w_state;
    logic [TW-1:0] r_tok, w_tok;
    logic [IW-1:0] r_idle, w_idle;
    logic [WW-1:0] r_wait, w_wait;
    logic          r_locked, r_bitslip, w_bitslip;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_SEARCH;
            r_tok     <= '0;
            r_idle    <= '0;
            r_wait    <= '0;
            r_locked  <= 1'b0;
            r_bitslip <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_tok     <= w_tok;
            r_idle    <= w_idle;
            r_wait    <= w_wait;
            r_locked  <= (w_state == ST_LOCKED);
            r_bitslip <= w_bitslip;
        end
    end

    // A token arriving on the timeout cycle wins over the bitslip
    always_comb begin
        w_state   = r_state;
        w_tok     = r_tok;
        w_idle    = r_idle;
        w_wait    = r_wait;
        w_bitslip = 1'b0;
        if (i_vld) begin
            unique case (r_state)
                ST_SEARCH: begin
                    if (i_ctrl) begin
                        w_idle = '0;
                        if (r_tok == TOK_LAST) begin
                            w_state = ST_LOCKED;
                            w_tok   = '0;
                        end else begin
                            w_tok = r_tok + TW'(1);
                        end
                    end else begin
                        w_tok = '0;
                        if (r_idle == IDLE_LAST) begin
                            w_state   = ST_SLIP_WAIT;
                            w_idle    = '0;
                            w_bitslip = 1'b1;
                        end else begin
                            w_idle = r_idle + IW'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    w_tok = '0;
                    if (i_ctrl) begin
                        w_idle = '0;
                    end else if (r_idle == IDLE_LAST) begin
                        w_state = ST_SEARCH;
                        w_idle  = '0;
                    end else begin
                        w_idle = r_idle + IW'(1);
                    end
                end
                ST_SLIP_WAIT: begin
                    w_tok  = '0;
                    w_idle = '0;
                    if (r_wait == WAIT_LAST) begin
                        w_state = ST_SEARCH;
                        w_wait  = '0;
                    end else begin
                        w_wait = r_wait + WW'(1);
                    end
                end
                default: begin
                    w_state = ST_SEARCH;
                    w_tok   = '0;
                    w_idle  = '0;
                    w_wait  = '0;
                end
            endcase
        end
    end

    assign o_locked  = r_locked;
    assign o_bitslip = r_bitslip;

endmodule

// File: rtl/tmds_decode.sv
// TMDS symbol decoder: two-stage pipeline from 10-bit symbol to
// pixel byte / control bits, with word-alignment tracking.
module tmds_decode
    import tmds_pkg::*;
#(
    parameter int LOCK_CNT       = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int SLIP_WAIT      = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [9:0] data_in,
    output logic [7:0] data_out,
    output logic       c0,
    output logic       c1,
    output logic       de,
    output logic       locked,
    output logic       bitslip
);

    logic [9:0] r_sym;
    logic       r_vld;
    logic [7:0] r_data;
    logic       r_c0, r_c1, r_de;

    logic       w_ctrl;
    logic [1:0] w_c;
    logic [7:0] w_q, w_d;

    assign w_ctrl = is_ctrl(r_sym);

    always_comb begin
        w_c = 2'b00;
        case (r_sym)
            CTRL_01: w_c = 2'b01;
            CTRL_10: w_c = 2'b10;
            CTRL_11: w_c = 2'b11;
            default: w_c = 2'b00;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain
    always_comb begin
        w_q    = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
        w_d    = '0;
        w_d[0] = w_q[0];
        for (int i = 1; i < 8; i++) begin
            w_d[i] = r_sym[8] ? (w_q[i] ^ w_q[i-1])
                              : ~(w_q[i] ^ w_q[i-1]);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sym  <= '0;
            r_vld  <= 1'b0;
            r_data <= '0;
            r_c0   <= 1'b0;
            r_c1   <= 1'b0;
            r_de   <= 1'b0;
        end else begin
            r_sym  <= data_in;
            r_vld  <= 1'b1;
            r_data <= (r_vld && !w_ctrl) ? w_d : 8'h00;
            r_c0   <= r_vld && w_ctrl && w_c[0];
            r_c1   <= r_vld && w_ctrl && w_c[1];
            r_de   <= r_vld && !w_ctrl;
        end
    end

    tmds_align_fsm #(
        .LOCK_CNT       (LOCK_CNT),
        .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
        .SLIP_WAIT      (SLIP_WAIT)
    ) u_align (
        .i_clk     (sys_clk),
        .i_rst_n   (sys_rst_n),
        .i_vld     (r_vld),
        .i_ctrl    (w_ctrl),
        .o_locked  (locked),
        .o_bitslip (bitslip)
    );

    assign data_out = r_data;
    assign c0       = r_c0;
    assign c1       = r_c1;
    assign de       = r_de;

endmodule
